sequence_checker: RTL and testbench
===================================

Name: sequence_checker

Overview:
- Sits directly downstream of the 4-bit sequence generator.
- Samples the generator's data bus on enabled cycles and locks onto the repeating 8-value pattern A,B,E,7,F,2,0,D.
- Flags per-symbol mismatches and counts completed frames and errors.
- Serves as the on-chip self-check for the generator, replacing bench-side value compares.

Parameters:
- ERR_CNT_W, 8: width of error_count; saturates at all-ones.
- FRM_CNT_W, 16: width of frame_count; saturates at all-ones.
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that force return to HUNT; legal range 1..7.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  sample qualifier; same signal that enables the generator.
- data  input  4  generator output.
- locked  output  1  high while FSM is in LOCKED.
- seq_error  output  1  one-cycle pulse per mismatched sample in LOCKED.
- frame_done  output  1  one-cycle pulse when a matching D completes a frame.
- error_count  output  ERR_CNT_W  saturating mismatch count.
- frame_count  output  FRM_CNT_W  saturating completed-frame count.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low (clk, reset_n).
  - reset_n low immediately forces: state=HUNT, exp_idx=0, miss_run=0, locked=0, seq_error=0, frame_done=0, both counters=0.
  - Reset applies at any time, including mid-frame; no partial state survives.
- Expected table, indexed 0..7: A,B,E,7,F,2,0,D. exp_idx is 3 bits and wraps 7->0 naturally.
- Sampling and latency:
  - data is sampled on the rising edge only when enable=1.
  - All outputs are registered and reflect that sample after the same edge (1-cycle latency).
- enable=0:
  - FSM, exp_idx, miss_run and counters hold.
  - seq_error and frame_done are 0.
  - locked holds its value.
- HUNT state:
  - Sample==A: go to LOCKED, exp_idx<=1, miss_run<=0.
  - Any other value: stay in HUNT, no error pulse, no count.
- LOCKED state, match (sample==table[exp_idx]):
  - exp_idx<=exp_idx+1, miss_run<=0.
  - If exp_idx==7: frame_done=1 and frame_count increments (saturating).
- LOCKED state, mismatch:
  - seq_error=1, error_count increments (saturating), miss_run increments.
  - exp_idx still advances, so a single corrupted symbol does not desynchronise the checker.
  - A mismatch at exp_idx==7 produces no frame_done.
- Loss of lock:
  - When a mismatch brings miss_run to LOSS_THRESH: go to HUNT, locked<=0, exp_idx<=0, miss_run<=0.
  - seq_error still pulses on that cycle.
  - No resync on A while LOCKED; resync only through HUNT.
- Saturation: at all-ones, a counter holds and further increment events are ignored. Pulses still fire.
- Simultaneous events: frame_done and seq_error are mutually exclusive by construction.

Optional Feature:
- Macro SEQ_CHECKER_ERR_CAPTURE_EN.
- When defined:
  - Adds output err_capture [7:0] = {expected, received}, captured on the first seq_error after reset.
  - Adds output err_valid [0:0], set on that same capture.
  - Both are sticky until reset_n; reset value is 0.
- When undefined: neither port exists, no capture logic is present, and all other behaviour is identical.

Test Plan:
- Clean stream: reset 20 ns, release, enable=1, drive A,B,E,7,F,2,0,D twice.
  - locked=1 after first A; frame_done pulses twice; frame_count=2; error_count=0; seq_error never high.
- Hunt filtering: drive 3,5,A,B... before the pattern.
  - No seq_error while in HUNT; lock on the A; frame_count=1 after D.
- Single glitch: in one frame, replace E with 9.
  - One seq_error pulse; error_count=1; locked stays 1; that frame gives no frame_done if the glitch is on D, otherwise frame_done is still given; the next frame counts normally.
- Loss of lock: LOSS_THRESH=3, drive 3 consecutive wrong values while LOCKED.
  - 3 seq_error pulses; locked=0 after the third; the following A relocks.
- Enable gating and reset: drop enable for 5 cycles mid-frame, with data changing to garbage.
  - No pulses and no count change; the pattern resumes from the held exp_idx.
  - Then assert reset_n=0 asynchronously mid-frame: all outputs 0 immediately.
- Saturation and feature: ERR_CNT_W=2, inject 5 isolated errors → error_count=3.
  - With SEQ_CHECKER_ERR_CAPTURE_EN, the first error (expected E, received 9) → err_capture=8'hE9 and err_valid=1, unchanged by later errors.

Source files
------------

// File: rtl/sequence_checker.sv
// Self-check for the 4-bit sequence generator: locks onto A,B,E,7,F,2,0,D, flags mismatches, counts frames/errors.
// Optional first-error capture port pair is built when SEQ_CHECKER_ERR_CAPTURE_EN is defined.
module sequence_checker #(
  parameter int ERR_CNT_W   = 8,
  parameter int FRM_CNT_W   = 16,
  parameter int LOSS_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [3:0]           data,
  output logic                 locked,
  output logic                 seq_error,
  output logic                 frame_done,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [FRM_CNT_W-1:0] frame_count
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
  ,
  output logic [7:0]           err_capture,
  output logic [0:0]           err_valid
`endif
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [2:0] LP_THRESH = 3'(LOSS_THRESH);

  state_t               r_state, w_state_next;
  logic [2:0]           r_exp_idx, w_exp_idx_next;
  logic [2:0]           r_miss_run, w_miss_run_next;
  logic                 r_seq_error, w_seq_error_next;
  logic                 r_frame_done, w_frame_done_next;
  logic [ERR_CNT_W-1:0] r_error_count, w_error_count_next;
  logic [FRM_CNT_W-1:0] r_frame_count, w_frame_count_next;
  logic [3:0]           w_expected;
  logic [2:0]           w_miss_inc;

  always_comb begin
    case (r_exp_idx)
      3'd0:    w_expected = 4'hA;
      3'd1:    w_expected = 4'hB;
      3'd2:    w_expected = 4'hE;
      3'd3:    w_expected = 4'h7;
      3'd4:    w_expected = 4'hF;
      3'd5:    w_expected = 4'h2;
      3'd6:    w_expected = 4'h0;
      default: w_expected = 4'hD;
    endcase
  end

  assign w_miss_inc = r_miss_run + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_HUNT;
      r_exp_idx     <= 3'd0;
      r_miss_run    <= 3'd0;
      r_seq_error   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_error_count <= '0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_exp_idx     <= w_exp_idx_next;
      r_miss_run    <= w_miss_run_next;
      r_seq_error   <= w_seq_error_next;
      r_frame_done  <= w_frame_done_next;
      r_error_count <= w_error_count_next;
      r_frame_count <= w_frame_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_exp_idx_next     = r_exp_idx;
    w_miss_run_next    = r_miss_run;
    w_seq_error_next   = 1'b0;
    w_frame_done_next  = 1'b0;
    w_error_count_next = r_error_count;
    w_frame_count_next = r_frame_count;
    if (enable) begin
      case (r_state)
        ST_HUNT: begin
          if (data == 4'hA) begin
            w_state_next    = ST_LOCKED;
            w_exp_idx_next  = 3'd1;
            w_miss_run_next = 3'd0;
          end
        end
        default: begin
          // Index advances on mismatch too, so one bad symbol cannot slip the frame alignment.
          w_exp_idx_next = r_exp_idx + 3'd1;
          if (data == w_expected) begin
            w_miss_run_next = 3'd0;
            if (r_exp_idx == 3'd7) begin
              w_frame_done_next = 1'b1;
              if (r_frame_count != '1)
                w_frame_count_next = r_frame_count + FRM_CNT_W'(1);
            end
          end else begin
            w_seq_error_next = 1'b1;
            if (r_error_count != '1)
              w_error_count_next = r_error_count + ERR_CNT_W'(1);
            if (w_miss_inc == LP_THRESH) begin
              w_state_next    = ST_HUNT;
              w_exp_idx_next  = 3'd0;
              w_miss_run_next = 3'd0;
            end else begin
              w_miss_run_next = w_miss_inc;
            end
          end
        end
      endcase
    end
  end

  assign locked      = (r_state == ST_LOCKED);
  assign seq_error   = r_seq_error;
  assign frame_done  = r_frame_done;
  assign error_count = r_error_count;
  assign frame_count = r_frame_count;

`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
  logic [7:0] r_err_capture;
  logic [0:0] r_err_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_capture <= 8'h00;
      r_err_valid   <= 1'b0;
    end else if (w_seq_error_next && !r_err_valid[0]) begin
      r_err_capture <= {w_expected, data};
      r_err_valid   <= 1'b1;
    end
  end

  assign err_capture = r_err_capture;
  assign err_valid   = r_err_valid;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed vector table, async-reset corner, then random stream vs a behavioural model.
// Two instances share stimulus: default widths and a 2-bit error counter to exercise saturation.
`timescale 1ns/1ps
module tb_sequence_checker;

  localparam int LT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  data = 4'h0;

  logic        a_locked, a_seq_error, a_frame_done;
  logic [7:0]  a_error_count;
  logic [15:0] a_frame_count;
  logic        b_locked, b_seq_error, b_frame_done;
  logic [1:0]  b_error_count;
  logic [15:0] b_frame_count;
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
  logic [7:0]  a_err_capture, b_err_capture;
  logic [0:0]  a_err_valid, b_err_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_checker #(.ERR_CNT_W(8), .FRM_CNT_W(16), .LOSS_THRESH(LT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data(data),
    .locked(a_locked), .seq_error(a_seq_error), .frame_done(a_frame_done),
    .error_count(a_error_count), .frame_count(a_frame_count)
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
    , .err_capture(a_err_capture), .err_valid(a_err_valid)
`endif
  );

  sequence_checker #(.ERR_CNT_W(2), .FRM_CNT_W(16), .LOSS_THRESH(LT)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data(data),
    .locked(b_locked), .seq_error(b_seq_error), .frame_done(b_frame_done),
    .error_count(b_error_count), .frame_count(b_frame_count)
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
    , .err_capture(b_err_capture), .err_valid(b_err_valid)
`endif
  );

  // Behavioural reference: the pattern as an array, counts as unbounded integers.
  logic [3:0] pat [8] = '{4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD};
  int         m_lk, m_pos, m_run, m_ecnt, m_fcnt, m_err, m_fd, m_capv;
  logic [7:0] m_cap;

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_reset();
    m_lk = 0; m_pos = 0; m_run = 0; m_ecnt = 0; m_fcnt = 0;
    m_err = 0; m_fd = 0; m_capv = 0; m_cap = 8'h00;
  endtask

  task automatic model_step(input bit en, input logic [3:0] d);
    m_err = 0;
    m_fd  = 0;
    if (!en) return;
    if (m_lk == 0) begin
      if (d == 4'hA) begin
        m_lk = 1; m_pos = 1; m_run = 0;
      end
      return;
    end
    if (d == pat[m_pos]) begin
      m_run = 0;
      if (m_pos == 7) begin
        m_fd = 1; m_fcnt++;
      end
    end else begin
      m_err = 1; m_ecnt++; m_run++;
      if (m_capv == 0) begin
        m_capv = 1; m_cap = {pat[m_pos], d};
      end
    end
    m_pos = (m_pos + 1) % 8;
    if (m_run >= LT) begin
      m_lk = 0; m_pos = 0; m_run = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit en, input logic [3:0] d);
    enable = en;
    data   = d;
    @(posedge clk);
    model_step(en, d);
    #1;
    $display("txn t=%0t en=%0d data=%h -> locked=%0d err=%0d fd=%0d ecnt=%0d fcnt=%0d",
             $time, en, d, a_locked, a_seq_error, a_frame_done, a_error_count, a_frame_count);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " locked"}, int'(a_locked), m_lk);
    chk({tag, " seq_error"}, int'(a_seq_error), m_err);
    chk({tag, " frame_done"}, int'(a_frame_done), m_fd);
    chk({tag, " error_count"}, int'(a_error_count), sat(m_ecnt, 8));
    chk({tag, " frame_count"}, int'(a_frame_count), sat(m_fcnt, 16));
    chk({tag, " sat locked"}, int'(b_locked), m_lk);
    chk({tag, " sat error_count"}, int'(b_error_count), sat(m_ecnt, 2));
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
    chk({tag, " err_valid"}, int'(a_err_valid), m_capv);
    chk({tag, " err_capture"}, int'(a_err_capture), int'(m_cap));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " locked"}, int'(a_locked), 0);
    chk({tag, " seq_error"}, int'(a_seq_error), 0);
    chk({tag, " frame_done"}, int'(a_frame_done), 0);
    chk({tag, " error_count"}, int'(a_error_count), 0);
    chk({tag, " frame_count"}, int'(a_frame_count), 0);
    chk({tag, " sat error_count"}, int'(b_error_count), 0);
    chk({tag, " sat frame_count"}, int'(b_frame_count), 0);
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
    chk({tag, " err_valid"}, int'(a_err_valid), 0);
    chk({tag, " err_capture"}, int'(a_err_capture), 0);
`endif
  endtask

  typedef struct {
    bit         en;
    logic [3:0] d;
    bit         lk;
    bit         se;
    bit         fd;
    int         ec;
    int         fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit en, input logic [3:0] d, input bit lk, input bit se,
                     input bit fd, input int ec, input int fc);
    vec_t v;
    v.en = en; v.d = d; v.lk = lk; v.se = se; v.fd = fd; v.ec = ec; v.fc = fc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] d;
    bit         en;
    int         p;

    // Hunt filtering, then two clean frames.
    add(1, 4'h3, 0, 0, 0, 0, 0);
    add(1, 4'h5, 0, 0, 0, 0, 0);
    add(1, 4'hA, 1, 0, 0, 0, 0);
    add(1, 4'hB, 1, 0, 0, 0, 0);
    add(1, 4'hE, 1, 0, 0, 0, 0);
    add(1, 4'h7, 1, 0, 0, 0, 0);
    add(1, 4'hF, 1, 0, 0, 0, 0);
    add(1, 4'h2, 1, 0, 0, 0, 0);
    add(1, 4'h0, 1, 0, 0, 0, 0);
    add(1, 4'hD, 1, 0, 1, 0, 1);
    add(1, 4'hA, 1, 0, 0, 0, 1);
    add(1, 4'hB, 1, 0, 0, 0, 1);
    add(1, 4'hE, 1, 0, 0, 0, 1);
    add(1, 4'h7, 1, 0, 0, 0, 1);
    add(1, 4'hF, 1, 0, 0, 0, 1);
    add(1, 4'h2, 1, 0, 0, 0, 1);
    add(1, 4'h0, 1, 0, 0, 0, 1);
    add(1, 4'hD, 1, 0, 1, 0, 2);
    // Glitch on E: error, frame still completes.
    add(1, 4'hA, 1, 0, 0, 0, 2);
    add(1, 4'hB, 1, 0, 0, 0, 2);
    add(1, 4'h9, 1, 1, 0, 1, 2);
    add(1, 4'h7, 1, 0, 0, 1, 2);
    add(1, 4'hF, 1, 0, 0, 1, 2);
    add(1, 4'h2, 1, 0, 0, 1, 2);
    add(1, 4'h0, 1, 0, 0, 1, 2);
    add(1, 4'hD, 1, 0, 1, 1, 3);
    // Glitch on D: error, no frame_done.
    add(1, 4'hA, 1, 0, 0, 1, 3);
    add(1, 4'hB, 1, 0, 0, 1, 3);
    add(1, 4'hE, 1, 0, 0, 1, 3);
    add(1, 4'h7, 1, 0, 0, 1, 3);
    add(1, 4'hF, 1, 0, 0, 1, 3);
    add(1, 4'h2, 1, 0, 0, 1, 3);
    add(1, 4'h0, 1, 0, 0, 1, 3);
    add(1, 4'h5, 1, 1, 0, 2, 3);
    // Next frame counts normally.
    add(1, 4'hA, 1, 0, 0, 2, 3);
    add(1, 4'hB, 1, 0, 0, 2, 3);
    add(1, 4'hE, 1, 0, 0, 2, 3);
    add(1, 4'h7, 1, 0, 0, 2, 3);
    add(1, 4'hF, 1, 0, 0, 2, 3);
    add(1, 4'h2, 1, 0, 0, 2, 3);
    add(1, 4'h0, 1, 0, 0, 2, 3);
    add(1, 4'hD, 1, 0, 1, 2, 4);
    // Three consecutive misses drop lock; A relocks.
    add(1, 4'hA, 1, 0, 0, 2, 4);
    add(1, 4'h1, 1, 1, 0, 3, 4);
    add(1, 4'h1, 1, 1, 0, 4, 4);
    add(1, 4'h1, 0, 1, 0, 5, 4);
    add(1, 4'h3, 0, 0, 0, 5, 4);
    add(1, 4'hA, 1, 0, 0, 5, 4);
    add(1, 4'hB, 1, 0, 0, 5, 4);
    add(1, 4'hE, 1, 0, 0, 5, 4);
    // Enable low with garbage data: everything holds.
    add(0, 4'h4, 1, 0, 0, 5, 4);
    add(0, 4'hA, 1, 0, 0, 5, 4);
    add(0, 4'hC, 1, 0, 0, 5, 4);
    add(0, 4'h8, 1, 0, 0, 5, 4);
    add(0, 4'h6, 1, 0, 0, 5, 4);
    add(1, 4'h7, 1, 0, 0, 5, 4);
    add(1, 4'hF, 1, 0, 0, 5, 4);
    add(1, 4'h2, 1, 0, 0, 5, 4);
    add(1, 4'h0, 1, 0, 0, 5, 4);
    add(1, 4'hD, 1, 0, 1, 5, 5);

    model_reset();
    #20;
    check_all_zero("reset");
    #2 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].d);
      chk($sformatf("vec%0d locked", i), int'(a_locked), int'(vecs[i].lk));
      chk($sformatf("vec%0d seq_error", i), int'(a_seq_error), int'(vecs[i].se));
      chk($sformatf("vec%0d frame_done", i), int'(a_frame_done), int'(vecs[i].fd));
      chk($sformatf("vec%0d error_count", i), int'(a_error_count), vecs[i].ec);
      chk($sformatf("vec%0d frame_count", i), int'(a_frame_count), vecs[i].fc);
      chk($sformatf("vec%0d sat error_count", i), int'(b_error_count), sat(vecs[i].ec, 2));
      chk($sformatf("vec%0d sat frame_done", i), int'(b_frame_done), int'(vecs[i].fd));
    end
`ifdef SEQ_CHECKER_ERR_CAPTURE_EN
    chk("capture sticky valid", int'(a_err_valid), 1);
    chk("capture sticky value", int'(a_err_capture), 8'hE9);
    chk("sat capture value", int'(b_err_capture), 8'hE9);
`endif

    // Asynchronous reset mid-frame while a seq_error pulse is showing.
    step(1, 4'hA);
    step(1, 4'hB);
    step(1, 4'h3);
    chk("pre-reset seq_error", int'(a_seq_error), 1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async reset");
    enable = 1'b1;
    data   = 4'hA;
    @(posedge clk);
    #1;
    check_all_zero("held in reset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 4'hB);
    check_model("post-reset hunt");

    // Random stream: mostly the correct pattern, with bursts of heavy corruption.
    p = 0;
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ((i % 200) < 25) d = (($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : pat[p]);
      else                d = (($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : pat[p]);
      if (en) p = (p + 1) % 8;
      step(en, d);
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
